// File: rtl/i2c_param_bank_pkg.sv
// Shared FSM states, bus ACK encodings and synchroniser depth for the I2C parameter bank.
// No timing or flow control of its own; types and constants only.
package i2c_param_bank_pkg;

   localparam int SYNC_DEPTH = 2;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } state_t;

   // Open-drain: a bus bit of 0 (including ACK) means pulling SDA low.
   function automatic logic oe_for(input logic bus_bit);
      return bus_bit == 1'b0;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and flags SCL edges, START and STOP as one-clk pulses.
// Events trail the pads by SYNC_DEPTH+1 clocks; no backpressure, consumers must take every pulse.
module i2c_bus_sync
   import i2c_param_bank_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   // Bits [SYNC_DEPTH-1:0] are the synchroniser, the top bit holds the previous level.
   logic [SYNC_DEPTH:0] scl_q;
   logic [SYNC_DEPTH:0] sda_q;
   logic                scl_cur;
   logic                scl_prv;
   logic                sda_cur;
   logic                sda_prv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[SYNC_DEPTH-1:0], scl_i};
         sda_q <= {sda_q[SYNC_DEPTH-1:0], sda_i};
      end
   end

   assign scl_cur    = scl_q[SYNC_DEPTH-1];
   assign scl_prv    = scl_q[SYNC_DEPTH];
   assign sda_cur    = sda_q[SYNC_DEPTH-1];
   assign sda_prv    = sda_q[SYNC_DEPTH];

   assign sda_o      = sda_cur;
   assign scl_rise_o = scl_cur & ~scl_prv;
   assign scl_fall_o = ~scl_cur & scl_prv;
   assign start_o    = scl_cur & scl_prv & sda_prv & ~sda_cur;
   assign stop_o     = scl_cur & scl_prv & ~sda_prv & sda_cur;

endmodule

// File: rtl/i2c_param_bank.sv
// I2C target exposing N_REGS gain registers with auto-incrementing pointer; ACK/data change on SCL fall,
// sampled on SCL rise. I2C_PARAM_BANK_SHADOW_EN stages writes in a shadow set committed at STOP.
module i2c_param_bank
   import i2c_param_bank_pkg::*;
#(
   parameter int          N_REGS   = 3,
   parameter int          REG_W    = 6,
   parameter logic [6:0]  DEV_ADDR = 7'h2A,
   parameter int unsigned RST_VAL  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic                      scl_in,
   input  logic                      sda_in,
   output logic                      sda_oe,
   output logic [N_REGS*REG_W-1:0]   regs_flat,
   output logic                      cfg_update
);

   localparam int               PTR_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [REG_W-1:0] RST_REG = REG_W'(RST_VAL);

   logic             sda_s;
   logic             scl_rise;
   logic             scl_fall;
   logic             start_det;
   logic             stop_det;

   state_t           state_q;
   logic [3:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_inc_d;
   logic             rw_q;
   logic             mack_q;
   logic             sda_oe_q;
   logic             cfg_update_q;
   logic [7:0]       rd_byte_d;
   logic [REG_W-1:0] regs_q [N_REGS];

   i2c_bus_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   assign ptr_inc_d = (ptr_q == PTR_W'(N_REGS - 1)) ? '0 : ptr_q + 1'b1;

`ifdef I2C_PARAM_BANK_SHADOW_EN
   logic [REG_W-1:0] shadow_q [N_REGS];
   logic             dirty_q;
   assign rd_byte_d = 8'(shadow_q[ptr_q]);
`else
   assign rd_byte_d = 8'(regs_q[ptr_q]);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         ptr_q        <= '0;
         rw_q         <= 1'b0;
         mack_q       <= 1'b0;
         sda_oe_q     <= 1'b0;
         cfg_update_q <= 1'b0;
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= RST_REG;
`ifdef I2C_PARAM_BANK_SHADOW_EN
         for (int i = 0; i < N_REGS; i++) shadow_q[i] <= RST_REG;
         dirty_q      <= 1'b0;
`endif
      end else begin
         cfg_update_q <= 1'b0;
         if (!ena) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
         end else if (start_det) begin
            state_q   <= ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
         end else if (stop_det) begin
            state_q   <= IDLE;
            sda_oe_q  <= 1'b0;
`ifdef I2C_PARAM_BANK_SHADOW_EN
            if (dirty_q) begin
               regs_q       <= shadow_q;
               dirty_q      <= 1'b0;
               cfg_update_q <= 1'b1;
            end
`endif
         end else begin
            case (state_q)
               ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= '0;
                     if (shift_q[7:1] == DEV_ADDR) begin
                        rw_q     <= shift_q[0];
                        sda_oe_q <= oe_for(ACK);
                        state_q  <= ADDR_ACK;
                     end else begin
                        state_q  <= WAIT_STOP;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt_q <= '0;
                     if (rw_q) begin
                        shift_q  <= rd_byte_d;
                        sda_oe_q <= oe_for(rd_byte_d[7]);
                        state_q  <= RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= PTR;
                     end
                  end
               end
               PTR: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= '0;
                     if (shift_q < 8'(N_REGS)) begin
                        ptr_q    <= PTR_W'(shift_q);
                        sda_oe_q <= oe_for(ACK);
                        state_q  <= PTR_ACK;
                     end else begin
                        state_q  <= WAIT_STOP;
                     end
                  end
               end
               PTR_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= WDATA;
                  end
               end
               WDATA: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= '0;
                     sda_oe_q  <= oe_for(ACK);
                     state_q   <= WDATA_ACK;
                  end
               end
               WDATA_ACK: begin
                  // Commit only once the ACK clock completes, so an abort mid-byte leaves registers intact.
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     ptr_q    <= ptr_inc_d;
                     state_q  <= WDATA;
`ifdef I2C_PARAM_BANK_SHADOW_EN
                     shadow_q[ptr_q] <= shift_q[REG_W-1:0];
                     dirty_q         <= 1'b1;
`else
                     regs_q[ptr_q]   <= shift_q[REG_W-1:0];
                     cfg_update_q    <= 1'b1;
`endif
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        bit_cnt_q <= '0;
                        sda_oe_q  <= 1'b0;
                        ptr_q     <= ptr_inc_d;
                        state_q   <= RDATA_ACK;
                     end else begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_oe_q  <= oe_for(shift_q[6]);
                     end
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise) begin
                     mack_q <= (sda_s == ACK);
                  end else if (scl_fall) begin
                     if (mack_q) begin
                        shift_q  <= rd_byte_d;
                        sda_oe_q <= oe_for(rd_byte_d[7]);
                        state_q  <= RDATA;
                     end else begin
                        state_q  <= WAIT_STOP;
                     end
                  end
               end
               IDLE, WAIT_STOP: begin
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_flat
      assign regs_flat[g*REG_W +: REG_W] = regs_q[g];
   end

   assign sda_oe     = sda_oe_q;
   assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_i2c_param_bank.sv
// Randomised I2C controller against a register-bank reference model; default and shadow builds.
module tb_i2c_param_bank;

   localparam int N_REGS = 3;
   localparam int REG_W  = 6;
   localparam int Q      = 6;
`ifdef I2C_PARAM_BANK_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic                    clk   = 1'b0;
   logic                    rst   = 1'b0;
   logic                    ena   = 1'b1;
   logic                    scl_m = 1'b1;
   logic                    sda_m = 1'b1;
   logic                    sda_bus;
   logic                    sda_oe;
   logic                    cfg_update;
   logic [N_REGS*REG_W-1:0] regs_flat;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_param_bank #(
      .N_REGS   (N_REGS),
      .REG_W    (REG_W),
      .DEV_ADDR (7'h2A),
      .RST_VAL  (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .scl_in     (scl_m),
      .sda_in     (sda_bus),
      .sda_oe     (sda_oe),
      .regs_flat  (regs_flat),
      .cfg_update (cfg_update)
   );

   always #5 clk = ~clk;

   int         checks  = 0;
   int         errors  = 0;
   int         cfg_cnt = 0;
   int         oe_cnt  = 0;
   int         exp_cfg = 0;
   int         m_regs [N_REGS];
   int         m_ptr   = 0;
   bit         m_dirty = 1'b0;
   logic [7:0] wbuf [4];

   always @(negedge clk) begin
      if (cfg_update) cfg_cnt++;
      if (sda_oe) oe_cnt++;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int model_flat();
      int r = 0;
      for (int i = 0; i < N_REGS; i++) r = r + (m_regs[i] << (i * REG_W));
      return r;
   endfunction

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bit_io(input logic v, output logic s);
      sda_m = v;
      wq();
      scl_m = 1'b1;
      wq();
      #1 s = sda_bus;
      wq();
      scl_m = 1'b0;
      wq();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wq();
      scl_m = 1'b1;
      wq();
      sda_m = 1'b0;
      wq();
      scl_m = 1'b0;
      wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wq();
      scl_m = 1'b1;
      wq();
      sda_m = 1'b1;
      wq();
   endtask

   task automatic stop_txn();
      i2c_stop();
      if (SHADOW && m_dirty) begin
         exp_cfg++;
         m_dirty = 1'b0;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output int ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
      bit_io(1'b1, s);
      ack = (s == 1'b0) ? 1 : 0;
   endtask

   task automatic read_byte(input int ack, output int b);
      logic s;
      b = 0;
      for (int i = 0; i < 8; i++) begin
         bit_io(1'b1, s);
         b = (b << 1) | int'(s);
      end
      bit_io((ack != 0) ? 1'b0 : 1'b1, s);
   endtask

   task automatic do_write(input logic [6:0] addr, input logic [7:0] p, input int n, input bit end_stop);
      int ack;
      int ok;
      i2c_start();
      ok = (ena && addr == 7'h2A) ? 1 : 0;
      write_byte({addr, 1'b0}, ack);
      check("addr_ack", ack, ok);
      ok = (ok != 0 && int'(p) < N_REGS) ? 1 : 0;
      write_byte(p, ack);
      check("ptr_ack", ack, ok);
      if (ok != 0) m_ptr = int'(p);
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], ack);
         check("data_ack", ack, ok);
         if (ok != 0) begin
            m_regs[m_ptr] = int'(wbuf[i]) % (1 << REG_W);
            m_ptr = (m_ptr + 1) % N_REGS;
            if (SHADOW) m_dirty = 1'b1;
            else exp_cfg++;
         end
      end
      if (end_stop) begin
         stop_txn();
         check("regs_flat", int'(regs_flat), model_flat());
         check("cfg_count", cfg_cnt, exp_cfg);
      end
   endtask

   task automatic do_read(input int n);
      int ack;
      int d;
      i2c_start();
      write_byte(8'h55, ack);
      check("raddr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         read_byte((i < n - 1) ? 1 : 0, d);
         check("rdata", d, m_regs[m_ptr]);
         m_ptr = (m_ptr + 1) % N_REGS;
      end
      stop_txn();
      check("regs_flat_rd", int'(regs_flat), model_flat());
      check("cfg_count_rd", cfg_cnt, exp_cfg);
   endtask

   initial begin
      int         ack;
      int         kind;
      int         o0;
      int         old_flat;
      logic       s;
      logic [6:0] a;

      for (int i = 0; i < N_REGS; i++) m_regs[i] = 0;

      #2 rst = 1'b1;
      #1;
      check("rst_oe", int'(sda_oe), 0);
      check("rst_flat", int'(regs_flat), 0);
      check("rst_cfg", int'(cfg_update), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wq();

      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h00;
      do_write(7'h2A, 8'h00, 3, 1'b1);
      check("flat_0x33891", int'(regs_flat), 32'h33891);

      do_write(7'h2A, 8'h02, 0, 1'b0);
      do_read(3);

      o0 = cfg_cnt;
      do_write(7'h2A, 8'h07, 0, 1'b1);
      check("badptr_no_cfg", cfg_cnt - o0, 0);
      do_read(1);

      o0 = oe_cnt;
      wbuf[0] = 8'h3F;
      do_write(7'h2B, 8'h00, 1, 1'b1);
      check("nomatch_oe", oe_cnt - o0, 0);

      wbuf[0] = 8'h11;
      do_write(7'h2A, 8'h00, 1, 1'b1);

      old_flat = model_flat();
      wbuf[0] = 8'h05;
      do_write(7'h2A, 8'h00, 1, 1'b0);
      check("pre_stop_flat", int'(regs_flat), SHADOW ? old_flat : model_flat());
      check("pre_stop_cfg", cfg_cnt, exp_cfg);
      stop_txn();
      check("post_stop_flat", int'(regs_flat), model_flat());
      check("post_stop_cfg", cfg_cnt, exp_cfg);

      ena = 1'b0;
      wbuf[0] = 8'h2C;
      do_write(7'h2A, 8'h01, 1, 1'b1);
      ena = 1'b1;
      wq();

      i2c_start();
      write_byte(8'h54, ack);
      check("pre_rst_ack", ack, 1);
      write_byte(8'h01, ack);
      bit_io(1'b0, s);
      sda_m = 1'b0;
      wq();
      scl_m = 1'b1;
      wq();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_oe", int'(sda_oe), 0);
      check("midrst_flat", int'(regs_flat), 0);
      rst = 1'b0;
      for (int i = 0; i < N_REGS; i++) m_regs[i] = 0;
      m_ptr   = 0;
      m_dirty = 1'b0;
      wq();
      scl_m = 1'b0;
      wq();
      i2c_stop();
      check("midrst_cfg", cfg_cnt, exp_cfg);
      do_read(1);
      wbuf[0] = 8'h15;
      do_write(7'h2A, 8'h01, 1, 1'b1);
      do_read(2);

      for (int t = 0; t < 24; t++) begin
         kind = int'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
         case (kind)
            0, 1: do_write(7'h2A, 8'($urandom_range(0, N_REGS + 1)), int'($urandom_range(0, 4)), 1'b1);
            2: begin
               if ($urandom_range(0, 1) == 1) do_write(7'h2A, 8'($urandom_range(0, N_REGS - 1)), 0, 1'b0);
               do_read(int'($urandom_range(1, 4)));
            end
            default: begin
               a = 7'($urandom);
               if (a == 7'h2A) a = 7'h2B;
               do_write(a, 8'($urandom_range(0, N_REGS - 1)), int'($urandom_range(0, 2)), 1'b1);
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
